noc_vc_input_queue: RTL

//  Per-input flit queue that feeds one request line of the NoC QoS arbiter.
//  - Buffers flits arriving from the upstream link.
//  - Presents a request and the packet's QoS level for the head flit.
//  - Pops on grant and returns one credit upstream per freed entry.
//  - One instance per arbiter input; arb_request/arb_qos/arb_grant wire to request[i]/qos_level[i]/grant[i].

---
 rtl/noc_vc_input_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/noc_vc_input_queue.sv
// rtl/noc_vc_input_queue.sv - per-input NoC flit queue with QoS request, grant pop and credit return
// Head entry drives the arbiter request/QoS and the departing flit fields combinationally.
module noc_vc_input_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int QOS_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_head,
  input  logic                       in_tail,
  input  logic [QOS_W-1:0]           in_qos,
  output logic                       arb_request,
  output logic [QOS_W-1:0]           arb_qos,
  input  logic                       arb_grant,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_head,
  output logic                       out_tail,
  output logic                       credit_return,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       protocol_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic              mem_head_q [DEPTH];
  logic              mem_tail_q [DEPTH];
  logic [QOS_W-1:0]  mem_qos_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [QOS_W-1:0] cur_qos_q, cur_qos_d;
  logic             in_pkt_q, in_pkt_d;
  logic             credit_q, credit_d;
  logic             err_q, err_d;

  logic             full, empty, push, pop;
  logic [QOS_W-1:0] push_qos;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Reset gating keeps handshake outputs low for the whole time rst_n is asserted.
  assign in_ready    = rst_n & ~full;
  assign arb_request = rst_n & ~empty;
  assign push        = in_valid & in_ready;
  assign pop         = arb_grant & arb_request;

  assign out_valid     = pop;
  assign out_data      = mem_data_q[rd_ptr_q];
  assign out_head      = mem_head_q[rd_ptr_q];
  assign out_tail      = mem_tail_q[rd_ptr_q];
  assign arb_qos       = mem_qos_q[rd_ptr_q];
  assign credit_return = credit_q;
  assign occupancy     = count_q;
  assign protocol_err  = err_q;

  // Body/tail flits inherit the QoS captured from the most recent head.
  assign push_qos = in_head ? in_qos : cur_qos_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cur_qos_d = cur_qos_q;
    in_pkt_d  = in_pkt_q;
    credit_d  = pop;
    err_d     = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (in_head) begin
        cur_qos_d = in_qos;
      end
      if (in_head && in_pkt_q) begin
        err_d = 1'b1;
      end
      if (!in_head && !in_pkt_q) begin
        err_d = 1'b1;
      end
      if (in_tail) begin
        in_pkt_d = 1'b0;
      end else if (in_head) begin
        in_pkt_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (arb_grant && !arb_request) begin
      err_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cur_qos_q <= '0;
      in_pkt_q  <= 1'b0;
      credit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cur_qos_q <= cur_qos_d;
      in_pkt_q  <= in_pkt_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_head_q[wr_ptr_q] <= in_head;
      mem_tail_q[wr_ptr_q] <= in_tail;
      mem_qos_q[wr_ptr_q]  <= push_qos;
    end
  end

endmodule
